// File: rtl/data_memory_pkg.sv
// Shared types and helpers for the parametrised data memory controller.
// Parity storage is enabled by defining DATA_MEMORY_PARITY_EN.
package data_memory_pkg;

    localparam int DMEM_DATA_W    = 8;
    localparam int DMEM_ADDR_W    = 4;
    localparam int DMEM_PAR_MAX_W = 64;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    // Callers zero-extend their word; extra zero bits do not change the parity.
    function automatic logic even_parity(input logic [DMEM_PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/dmem_array_1r1w.sv
// Plain synchronous storage: one write port, one registered read port.
// Read-before-write on a same-address collision, as block RAM behaves.
module dmem_array_1r1w
    import data_memory_pkg::*;
#(
    parameter int WIDTH = DMEM_DATA_W,
    parameter int DEPTH = 16,
    parameter int AW    = DMEM_ADDR_W
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [WIDTH-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
        if (re) begin
            rdata_reg <= mem_reg[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/data_memory_ctrl.sv
// Registered-read data memory with ready/valid requests, zero-fill after reset
// and out-of-range detection. Define DATA_MEMORY_PARITY_EN for per-word parity.
module data_memory_ctrl
    import data_memory_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] access_addr,
    input  logic [DATA_W-1:0] write_data,
    output logic              ready,
    output logic [DATA_W-1:0] read_data,
    output logic              read_valid,
    output logic              addr_err
`ifdef DATA_MEMORY_PARITY_EN
    ,
    output logic              parity_err
`endif
);

`ifdef DATA_MEMORY_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_L  = (ADDR_W + 1)'(DEPTH - 1);

    state_t            state_reg;
    logic [ADDR_W:0]   clr_ptr_reg;
    logic              read_valid_reg;
    logic              addr_err_reg;
    logic              zero_reg;

    logic              in_range;
    logic              running;
    logic              arr_we;
    logic              arr_re;
    logic [ADDR_W-1:0] arr_waddr;
    logic [WORD_W-1:0] arr_wdata;
    logic [WORD_W-1:0] arr_rdata;
    logic [WORD_W-1:0] word_in;

    assign in_range = ({1'b0, access_addr} < DEPTH_L);
    assign running  = (state_reg == ST_RUN);

`ifdef DATA_MEMORY_PARITY_EN
    assign word_in = {even_parity(DMEM_PAR_MAX_W'(write_data)), write_data};
`else
    assign word_in = write_data;
`endif

    // Reset wins over both the clear sweep and any request in the same cycle.
    assign arr_we    = !rst && (running ? (mem_write && in_range) : 1'b1);
    assign arr_waddr = running ? access_addr : clr_ptr_reg[ADDR_W-1:0];
    assign arr_wdata = running ? word_in : '0;
    assign arr_re    = !rst && running && mem_read && in_range;

    dmem_array_1r1w #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH),
        .AW    (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .re    (arr_re),
        .raddr (access_addr),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_CLEAR;
            clr_ptr_reg    <= '0;
            read_valid_reg <= 1'b0;
            addr_err_reg   <= 1'b0;
            zero_reg       <= 1'b1;
        end else begin
            case (state_reg)
                ST_CLEAR: begin
                    clr_ptr_reg    <= clr_ptr_reg + (ADDR_W + 1)'(1);
                    read_valid_reg <= 1'b0;
                    addr_err_reg   <= 1'b0;
                    if (clr_ptr_reg == LAST_L) begin
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    read_valid_reg <= mem_read;
                    addr_err_reg   <= (mem_read || mem_write) && !in_range;
                    // zero_reg masks the RAM output so an out-of-range read yields 0.
                    if (mem_read) begin
                        zero_reg <= !in_range;
                    end
                end
                default: state_reg <= ST_CLEAR;
            endcase
        end
    end

    assign ready      = running;
    assign read_data  = zero_reg ? '0 : arr_rdata[DATA_W-1:0];
    assign read_valid = read_valid_reg;
    assign addr_err   = addr_err_reg;

`ifdef DATA_MEMORY_PARITY_EN
    assign parity_err = read_valid_reg && !zero_reg && (^arr_rdata);
`endif

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: a DEPTH=16 and a DEPTH=12 instance,
// reads scored against a queue filled by a reference memory model.
module tb_data_memory_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       mem_read = 1'b0;
    logic       mem_write = 1'b0;
    logic [3:0] access_addr = '0;
    logic [7:0] write_data = '0;
    logic       sel = 1'b0;

    logic       a_ready, a_valid, a_err, b_ready, b_valid, b_err;
    logic [7:0] a_rdata, b_rdata;
`ifdef DATA_MEMORY_PARITY_EN
    logic       a_perr, b_perr;
`endif

    always #5 clk = ~clk;

    data_memory_ctrl #(.DATA_W(8), .ADDR_W(4), .DEPTH(16)) dut_a (
        .clk         (clk),
        .rst         (rst),
        .mem_read    (mem_read & ~sel),
        .mem_write   (mem_write & ~sel),
        .access_addr (access_addr),
        .write_data  (write_data),
        .ready       (a_ready),
        .read_data   (a_rdata),
        .read_valid  (a_valid),
        .addr_err    (a_err)
`ifdef DATA_MEMORY_PARITY_EN
        ,
        .parity_err  (a_perr)
`endif
    );

    data_memory_ctrl #(.DATA_W(8), .ADDR_W(4), .DEPTH(12)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .mem_read    (mem_read & sel),
        .mem_write   (mem_write & sel),
        .access_addr (access_addr),
        .write_data  (write_data),
        .ready       (b_ready),
        .read_data   (b_rdata),
        .read_valid  (b_valid),
        .addr_err    (b_err)
`ifdef DATA_MEMORY_PARITY_EN
        ,
        .parity_err  (b_perr)
`endif
    );

    typedef struct {
        logic [7:0] data;
        logic       perr;
    } exp_t;

    exp_t       sb[$];
    int         depth_m [2] = '{16, 12};
    logic [7:0] model_mem [2][16];
    logic       model_perr [16];
    int         clr_left [2] = '{16, 12};
    logic [7:0] last_rd [2] = '{8'h00, 8'h00};
    int         tests = 0;
    int         fails = 0;

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic rd, input logic wr,
                        input logic [3:0] a, input logic [7:0] d);
        int   s;
        logic acc, oob, o_ready, o_valid, o_err, o_perr;
        logic [7:0] o_rdata;
        exp_t e;
        s = int'(sel);
        rst = r; mem_read = rd; mem_write = wr; access_addr = a; write_data = d;
        acc = !r && (clr_left[s] == 0) && (rd || wr);
        oob = int'(a) >= depth_m[s];
        if (acc && rd) begin
            e.data = oob ? 8'h00 : model_mem[s][a];
            e.perr = (s == 0) && !oob && model_perr[a];
            sb.push_back(e);
        end
        if (acc && wr && !oob) begin
            model_mem[s][a] = d;
            if (s == 0) model_perr[a] = 1'b0;
        end
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                clr_left[k] = depth_m[k];
                last_rd[k]  = 8'h00;
                for (int j = 0; j < 16; j++) model_mem[k][j] = 8'h00;
            end else if (clr_left[k] > 0) begin
                clr_left[k]--;
            end
        end
        if (r) for (int j = 0; j < 16; j++) model_perr[j] = 1'b0;
        @(posedge clk); #1;
        o_ready = sel ? b_ready : a_ready;
        o_valid = sel ? b_valid : a_valid;
        o_err   = sel ? b_err   : a_err;
        o_rdata = sel ? b_rdata : a_rdata;
`ifdef DATA_MEMORY_PARITY_EN
        o_perr  = sel ? b_perr  : a_perr;
`else
        o_perr  = 1'b0;
`endif
        check("ready", int'(o_ready), int'(clr_left[s] == 0));
        check("read_valid", int'(o_valid), int'(acc && rd));
        check("addr_err", int'(o_err), int'(acc && oob));
        if (o_valid && sb.size() > 0) begin
            e = sb.pop_front();
            check("read_data", int'(o_rdata), int'(e.data));
            check("parity_err", int'(o_perr), int'(e.perr));
            last_rd[s] = e.data;
            $display("[TB] t=%0t dut=%0d read addr=%0d data=0x%02h", $time, s, a, o_rdata);
        end else begin
            check("read_data_hold", int'(o_rdata), int'(last_rd[s]));
            check("parity_idle", int'(o_perr), 0);
        end
        if (sb.size() > 0) begin
            check("read_lost", sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++)
            for (int j = 0; j < 16; j++) model_mem[k][j] = 8'h00;
        for (int j = 0; j < 16; j++) model_perr[j] = 1'b0;

        // Reset and clear: ready rises exactly 16 edges after release.
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 18; i++) step(0, 1, 0, 4'd3, 0);

        // Write then read, then idle hold.
        step(0, 0, 1, 4'd7, 8'hA5);
        step(0, 1, 0, 4'd7, 0);
        step(0, 0, 0, 4'd7, 0);
        step(0, 0, 0, 4'd7, 0);

        // Simultaneous read and write: old data first, new data next.
        step(0, 0, 1, 4'd2, 8'h11);
        step(0, 1, 1, 4'd2, 8'h22);
        step(0, 1, 0, 4'd2, 0);

        // Top in-range word and back-to-back reads.
        step(0, 0, 1, 4'd15, 8'h3C);
        for (int i = 0; i < 16; i++) step(0, 1, 0, 4'(15 - i), 0);

        // Out-of-range on the DEPTH=12 instance.
        sel = 1'b1;
        step(0, 0, 1, 4'd11, 8'h55);
        step(0, 0, 1, 4'd0, 8'h66);
        step(0, 0, 1, 4'd13, 8'hFF);
        step(0, 1, 0, 4'd11, 0);
        step(0, 1, 0, 4'd13, 0);
        step(0, 1, 0, 4'd12, 0);
        for (int i = 0; i < 12; i++) step(0, 1, 0, 4'(i), 0);
        step(0, 1, 0, 4'd15, 0);
        step(0, 0, 0, 4'd0, 0);
        sel = 1'b0;

        // Reset mid-run with a write pending, then reset again at clear cycle 5.
        step(1, 0, 1, 4'd7, 8'hEE);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 1, 0, 4'd3, 0);
        for (int i = 0; i < 16; i++) step(0, 1, 0, 4'(i), 0);

`ifdef DATA_MEMORY_PARITY_EN
        step(0, 0, 1, 4'd1, 8'h0F);
        dut_a.u_array.mem_reg[1][0] = ~dut_a.u_array.mem_reg[1][0];
        model_mem[0][1] = model_mem[0][1] ^ 8'h01;
        model_perr[1] = 1'b1;
        step(0, 1, 0, 4'd1, 0);
        step(0, 1, 0, 4'd2, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
